// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel between fetch and imem
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding instruction fetch with redirect and stale-response drop; optional FETCH_MISALIGN_CHK_EN halts on misaligned pc
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [63:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          fetch_o_instr,
    output logic                 fetch_o_commit,
    output logic [63:0]          fetch_o_commit_pc,
    output logic [31:0]          fetch_o_commit_instr,
    output logic [63:0]          fetch_o_commit_pre_pc,
    output logic                 fetch_o_misalign
);
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [63:0] pc, pc_nxt, pc_inc;
    logic        deliver, mis;

    // misaligned pc detection; a flagged pc never reaches memory
    always_comb begin
`ifdef FETCH_MISALIGN_CHK_EN
        mis = !rst && state == S_REQ && !redirect_valid && pc[1:0] != 2'b00;
`else
        mis = 1'b0;
`endif
    end

    // request channel, delivery decision and bubble/commit outputs
    always_comb begin
        pc_inc                = pc + 64'd4;
        deliver               = !rst && state == S_WAIT && imem.imem_resp_valid && !redirect_valid;
        imem.imem_req_valid   = !rst && state == S_REQ && !redirect_valid && !mis;
        imem.imem_req_addr    = pc;
        fetch_o_commit        = deliver;
        fetch_o_instr         = deliver ? imem.imem_resp_data : NOP_INSTR;
        fetch_o_commit_instr  = deliver ? imem.imem_resp_data : 32'd0;
        fetch_o_commit_pc     = deliver ? pc : 64'd0;
        fetch_o_commit_pre_pc = deliver ? pc_inc : 64'd0;
        fetch_o_misalign      = mis;
    end

    // next pc: a redirect always wins, otherwise advance only on delivery
    always_comb begin
        pc_nxt = redirect_valid ? redirect_pc : deliver ? pc_inc : pc;
    end

    // FSM transitions; responses outside S_WAIT/S_DROP are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   state_nxt = redirect_valid ? S_REQ :
                                 mis ? S_HALT :
                                 imem.imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  state_nxt = imem.imem_resp_valid ? S_REQ :
                                 redirect_valid ? S_DROP : S_WAIT;
            S_DROP:  state_nxt = imem.imem_resp_valid ? S_REQ : S_DROP;
            default: state_nxt = redirect_valid ? S_REQ : S_HALT;
        endcase
    end

    // architectural state register; memory resets alongside so no drop after rst
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= S_REQ;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] fetch_o_instr;
    logic        fetch_o_commit;
    logic [63:0] fetch_o_commit_pc;
    logic [31:0] fetch_o_commit_instr;
    logic [63:0] fetch_o_commit_pre_pc;
    logic        fetch_o_misalign;
    int          checks = 0;
    int          errors = 0;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .imem                  (imem),
        .fetch_o_instr         (fetch_o_instr),
        .fetch_o_commit        (fetch_o_commit),
        .fetch_o_commit_pc     (fetch_o_commit_pc),
        .fetch_o_commit_instr  (fetch_o_commit_instr),
        .fetch_o_commit_pre_pc (fetch_o_commit_pre_pc),
        .fetch_o_misalign      (fetch_o_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bubble(input string tag);
        chk({tag, "_commit"}, {63'd0, fetch_o_commit}, 64'd0);
        chk({tag, "_instr"}, {32'd0, fetch_o_instr}, 64'h13);
        chk({tag, "_cpc"}, fetch_o_commit_pc, 64'd0);
        chk({tag, "_cinstr"}, {32'd0, fetch_o_commit_instr}, 64'd0);
        chk({tag, "_prepc"}, fetch_o_commit_pre_pc, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        imem.imem_req_ready = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data = 32'd0;
        tick();
        settle();
        chk("rst_req_valid", {63'd0, imem.imem_req_valid}, 64'd0);
        chk("rst_misalign", {63'd0, fetch_o_misalign}, 64'd0);
        bubble("rst");
        rst = 1'b0;
        settle();
        chk("first_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("first_req_addr", imem.imem_req_addr, 64'h8000_0000);
        tick();
        imem.imem_req_ready = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data = 32'h0050_0093;
        settle();
        chk("d1_commit", {63'd0, fetch_o_commit}, 64'd1);
        chk("d1_instr", {32'd0, fetch_o_instr}, 64'h0050_0093);
        chk("d1_cinstr", {32'd0, fetch_o_commit_instr}, 64'h0050_0093);
        chk("d1_cpc", fetch_o_commit_pc, 64'h8000_0000);
        chk("d1_prepc", fetch_o_commit_pre_pc, 64'h8000_0004);
        chk("wait_no_req", {63'd0, imem.imem_req_valid}, 64'd0);
        tick();
        imem.imem_resp_valid = 1'b0;
        settle();
        chk("next_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("next_req_addr", imem.imem_req_addr, 64'h8000_0004);
        bubble("post_d1");
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            chk("stall_req_valid", {63'd0, imem.imem_req_valid}, 64'd1);
            chk("stall_req_addr", imem.imem_req_addr, 64'h8000_0004);
            bubble("stall");
        end
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        settle();
        bubble("redir_wait");
        chk("redir_wait_req", {63'd0, imem.imem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data = 32'hDEAD_BEEF;
        settle();
        bubble("drop");
        chk("drop_req", {63'd0, imem.imem_req_valid}, 64'd0);
        tick();
        imem.imem_resp_valid = 1'b0;
        settle();
        chk("after_drop_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("after_drop_addr", imem.imem_req_addr, 64'h8000_1000);
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2000;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data = 32'h1111_1111;
        settle();
        bubble("redir_resp");
        tick();
        redirect_valid = 1'b0;
        imem.imem_resp_valid = 1'b0;
        settle();
        chk("redir_resp_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("redir_resp_addr", imem.imem_req_addr, 64'h8000_2000);
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        settle();
        chk("redir_req_gated", {63'd0, imem.imem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        imem.imem_req_ready = 1'b1;
        settle();
        chk("top_addr", imem.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        imem.imem_req_ready = 1'b0;
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data = 32'h0010_0073;
        settle();
        chk("wrap_commit", {63'd0, fetch_o_commit}, 64'd1);
        chk("wrap_cpc", fetch_o_commit_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_prepc", fetch_o_commit_pre_pc, 64'd0);
        tick();
        imem.imem_resp_valid = 1'b0;
        settle();
        chk("wrap_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("wrap_addr", imem.imem_req_addr, 64'd0);
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data = 32'h2222_2222;
        settle();
        bubble("proto_err");
        tick();
        imem.imem_resp_valid = 1'b0;
        settle();
        chk("proto_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("proto_addr", imem.imem_req_addr, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        settle();
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_flag", {63'd0, fetch_o_misalign}, 64'd1);
        chk("mis_no_req", {63'd0, imem.imem_req_valid}, 64'd0);
        bubble("mis");
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk("halt_flag", {63'd0, fetch_o_misalign}, 64'd0);
            chk("halt_no_req", {63'd0, imem.imem_req_valid}, 64'd0);
            bubble("halt");
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("resume_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("resume_addr", imem.imem_req_addr, 64'h8000_0100);
`else
        chk("mis_flag", {63'd0, fetch_o_misalign}, 64'd0);
        chk("mis_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("mis_addr", imem.imem_req_addr, 64'h8000_0002);
`endif
        imem.imem_req_ready = 1'b1;
        tick();
        imem.imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        settle();
        chk("midrst_req", {63'd0, imem.imem_req_valid}, 64'd0);
        bubble("midrst");
        rst = 1'b0;
        settle();
        chk("midrst_resume_req", {63'd0, imem.imem_req_valid}, 64'd1);
        chk("midrst_resume_addr", imem.imem_req_addr, 64'h8000_0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
